// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester and uart-side signals shared by the uart transmit arbiter.
// Latency: none; this interface only carries wires.
// Backpressure: req is held until req_ack; uart_is_transmitting holds off the next strobe.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_byte;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ack;
    logic [N_REQ-1:0]   grant;
    logic               uart_transmit;
    logic [7:0]         uart_tx_byte;
    logic               uart_is_transmitting;
    logic               busy;

    // Arbiter side: consumes requests and the uart busy flag, drives grant/ack/strobe.
    modport master (
        input  req, req_byte, req_last, uart_is_transmitting,
        output req_ack, grant, uart_transmit, uart_tx_byte, busy
    );

    // Requester and uart side.
    modport slave (
        output req, req_byte, req_last, uart_is_transmitting,
        input  req_ack, grant, uart_transmit, uart_tx_byte, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one uart transmitter among N_REQ message sources, round-robin, one whole message per grant.
// Latency: grant 1 cycle after req seen in IDLE; uart_transmit and req_ack 1 cycle after SEND.
// Backpressure: req is a level held until req_ack; the uart busy flag paces bytes; watchdogs release stuck grants.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int MAX_MSG_LEN  = 64,
    parameter int HOLD_TIMEOUT = 1023,
    parameter int GAP_CYCLES   = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    uart_tx_arbiter_if.master bus
);
    localparam int IDX_W   = $clog2(N_REQ);
    localparam int CNT_W   = $clog2(MAX_MSG_LEN + 1);
    localparam int TMR_MAX = (HOLD_TIMEOUT > GAP_CYCLES) ? HOLD_TIMEOUT : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_MSG_LEN);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? TMR_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_START,
        WAIT_DONE,
        HOLD,
        GAP
    } state_t;

    // With no gap configured a released grant goes straight back to arbitration.
    localparam state_t REL_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_winner;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   r_ack;
    logic               r_transmit;
    logic [7:0]         r_tx_byte;
    logic               r_last_q;
    logic [CNT_W-1:0]   r_cnt;
    logic [TMR_W-1:0]   r_tmr;
    logic [1:0]         r_ws;

    logic [2*N_REQ-1:0] w_dbl;
    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    int                 w_sum;
    logic               w_req_win;
    logic [7:0]         w_byte;
    logic               w_last;
    logic [IDX_W-1:0]   w_ptr_next;

    // Round-robin pick: rotate the request vector so the pointer lands at bit 0, take the first set bit.
    always_comb begin
        w_dbl   = {bus.req, bus.req} >> r_ptr;
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && w_dbl[k]) begin
                w_found = 1'b1;
                w_sum   = int'(r_ptr) + k;
                w_win   = IDX_W'((w_sum >= N_REQ) ? (w_sum - N_REQ) : w_sum);
            end
        end
    end

    // Current owner's request view and the pointer value used on release.
    always_comb begin
        w_req_win  = bus.req[r_winner];
        w_byte     = bus.req_byte[{r_winner, 3'b000} +: 8];
        w_last     = bus.req_last[r_winner];
        w_ptr_next = (int'(r_winner) == N_REQ - 1) ? '0 : r_winner + 1'b1;
    end

    // Arbiter FSM with registered grant, ack, strobe and byte outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_winner   <= '0;
            r_grant    <= '0;
            r_ack      <= '0;
            r_transmit <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_last_q   <= 1'b0;
            r_cnt      <= '0;
            r_tmr      <= '0;
            r_ws       <= '0;
        end else begin
            r_ack      <= '0;
            r_transmit <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A frame still on the line (e.g. after a reset) blocks arbitration.
                    if (!bus.uart_is_transmitting && w_found) begin
                        r_winner <= w_win;
                        r_grant  <= N_REQ'(1) << w_win;
                        r_cnt    <= '0;
                        r_state  <= SEND;
                    end
                end
                SEND: begin
                    if (!bus.uart_is_transmitting) begin
                        if (w_req_win) begin
                            r_transmit <= 1'b1;
                            r_ack      <= r_grant;
                            r_tx_byte  <= w_byte;
                            r_last_q   <= w_last;
                            if (r_cnt != CNT_MAX) begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                            r_ws    <= '0;
                            r_state <= WAIT_START;
                        end else begin
                            // Owner withdrew before its first byte: let the hold watchdog decide.
                            r_tmr   <= '0;
                            r_state <= HOLD;
                        end
                    end
                end
                WAIT_START: begin
                    // Give the uart 4 cycles to raise busy; a missing flag counts as already sent.
                    if (bus.uart_is_transmitting || r_ws == 2'd3) begin
                        r_state <= WAIT_DONE;
                    end else begin
                        r_ws <= r_ws + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.uart_is_transmitting) begin
                        if (r_last_q || r_cnt == CNT_MAX) begin
                            r_grant <= '0;
                            r_ptr   <= w_ptr_next;
                            r_tmr   <= '0;
                            r_state <= REL_STATE;
                        end else if (w_req_win) begin
                            r_state <= SEND;
                        end else begin
                            r_tmr   <= '0;
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_req_win) begin
                        r_state <= SEND;
                    end else if (r_tmr == HOLD_LAST) begin
                        r_grant <= '0;
                        r_ptr   <= w_ptr_next;
                        r_tmr   <= '0;
                        r_state <= REL_STATE;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                GAP: begin
                    if (r_tmr == GAP_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ack       = r_ack;
    assign bus.grant         = r_grant;
    assign bus.uart_transmit = r_transmit;
    assign bus.uart_tx_byte  = r_tx_byte;
    assign bus.busy          = (r_state != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 20-cycle uart model and queue-driven requesters.
// Latency: checks arbitration and strobe timing cycle-exactly, plus the hold watchdog count.
// Backpressure: requesters hold req until acked; the uart model holds busy for 20 cycles per byte.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(
        .N_REQ(N), .MAX_MSG_LEN(64), .HOLD_TIMEOUT(1023), .GAP_CYCLES(0)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [8:0] mem [N][256];
    int         head [N];
    int         tail [N];
    logic [7:0] log_byte [512];
    int         log_own [512];
    int         tx_n = 0;
    int         ack_cnt [N];
    int         inv_err = 0;
    logic       u_busy = 1'b0;
    int         ucnt = 0;

    // Monitor, uart model and requester drivers, all evaluated at the falling edge.
    always @(negedge clk) begin
        int own;
        int nack;
        own = -1;
        for (int i = 0; i < N; i++) if (bus.grant[i]) own = i;
        if (bus.uart_transmit) begin
            if (u_busy) inv_err++;
            if (tx_n < 512) begin
                log_byte[tx_n] = bus.uart_tx_byte;
                log_own[tx_n]  = own;
            end
            tx_n++;
        end
        nack = 0;
        for (int i = 0; i < N; i++) begin
            if (bus.req_ack[i]) begin
                nack++;
                ack_cnt[i]++;
                head[i]++;
                if (!bus.grant[i]) inv_err++;
            end
        end
        if (nack > 1) inv_err++;
        if ((nack != 0) != bus.uart_transmit) inv_err++;
        if (bus.uart_transmit) begin
            u_busy = 1'b1;
            ucnt   = 20;
        end else if (ucnt > 0) begin
            ucnt--;
            if (ucnt == 0) u_busy = 1'b0;
        end
        bus.uart_is_transmitting = u_busy;
        for (int i = 0; i < N; i++) begin
            bus.req[i]              = (head[i] < tail[i]);
            bus.req_last[i]         = mem[i][head[i] % 256][8];
            bus.req_byte[8*i +: 8]  = mem[i][head[i] % 256][7:0];
        end
    end

    task automatic push(input int i, input logic [7:0] b, input logic l);
        mem[i][tail[i] % 256] = {l, b};
        tail[i]++;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) tail[i] = head[i];
        rst = 1'b0;
    endtask

    task automatic settle();
        int c = 0;
        while (u_busy && c < 200) begin @(posedge clk); #1; c++; end
        n_cmp++;
        if (u_busy) begin n_fail++; $display("FAIL settle: uart busy=%0b after %0d cycles, want 0", u_busy, c); end
        apply_reset();
    endtask

    task automatic wait_tx(input int target, input int bound, input string nm);
        int c = 0;
        while (tx_n < target && c < bound) begin @(posedge clk); #1; c++; end
        n_cmp++;
        if (tx_n < target) begin n_fail++; $display("FAIL %s: strobes=%0d, want %0d", nm, tx_n, target); end
    endtask

    task automatic wait_idle(input int bound, input string nm);
        int c = 0;
        while ((bus.busy || u_busy) && c < bound) begin @(posedge clk); #1; c++; end
        n_cmp++;
        if (bus.busy || u_busy) begin n_fail++; $display("FAIL %s: busy=%0b uart=%0b, want idle", nm, bus.busy, u_busy); end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL rst_grant: got %b want 0000", bus.grant); end
        n_cmp++; if (bus.req_ack !== 4'b0000) begin n_fail++; $display("FAIL rst_ack: got %b want 0000", bus.req_ack); end
        n_cmp++; if (bus.uart_transmit !== 1'b0) begin n_fail++; $display("FAIL rst_tx: got %b want 0", bus.uart_transmit); end
        n_cmp++; if (bus.uart_tx_byte !== 8'h00) begin n_fail++; $display("FAIL rst_byte: got %h want 00", bus.uart_tx_byte); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_single();
        logic [7:0] exp_b [3];
        int base, a0;
        exp_b[0] = 8'h4F; exp_b[1] = 8'h4B; exp_b[2] = 8'h0A;
        settle();
        base = tx_n; a0 = ack_cnt[0];
        push(0, 8'h4F, 1'b0); push(0, 8'h4B, 1'b0); push(0, 8'h0A, 1'b1);
        @(posedge clk); #1;
        n_cmp++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", bus.grant); end
        @(posedge clk); #1;
        n_cmp++; if (bus.uart_transmit !== 1'b1) begin n_fail++; $display("FAIL single_strobe: got %b want 1", bus.uart_transmit); end
        n_cmp++; if (bus.uart_tx_byte !== 8'h4F) begin n_fail++; $display("FAIL single_first: got %h want 4f", bus.uart_tx_byte); end
        n_cmp++; if (bus.req_ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b want 0001", bus.req_ack); end
        wait_tx(base + 3, 200, "single_wait");
        wait_idle(100, "single_idle");
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (log_byte[base+k] !== exp_b[k] || log_own[base+k] != 0) begin
                n_fail++; $display("FAIL single_b%0d: got %h/own%0d want %h/own0", k, log_byte[base+k], log_own[base+k], exp_b[k]); end
        end
        n_cmp++; if (ack_cnt[0] - a0 != 3) begin n_fail++; $display("FAIL single_acks: got %0d want 3", ack_cnt[0] - a0); end
        n_cmp++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL single_release: got %b want 0000", bus.grant); end
    endtask

    task automatic test_contention();
        logic [7:0] exp_b [4];
        int exp_o [4];
        int base;
        exp_b[0] = 8'hA0; exp_b[1] = 8'hA1; exp_b[2] = 8'hC0; exp_b[3] = 8'hC1;
        exp_o[0] = 0; exp_o[1] = 0; exp_o[2] = 2; exp_o[3] = 2;
        settle();
        base = tx_n;
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
        push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
        wait_tx(base + 4, 400, "cont_wait");
        wait_idle(100, "cont_idle");
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (log_byte[base+k] !== exp_b[k] || log_own[base+k] != exp_o[k]) begin
                n_fail++; $display("FAIL cont_b%0d: got %h/own%0d want %h/own%0d", k, log_byte[base+k], log_own[base+k], exp_b[k], exp_o[k]); end
        end
        // Pointer should now sit at 3, so requester 3 beats requester 1.
        push(1, 8'hB1, 1'b1); push(3, 8'hD3, 1'b1);
        wait_tx(base + 6, 200, "cont_ptr_wait");
        n_cmp++; if (log_own[base+4] != 3 || log_own[base+5] != 1) begin
            n_fail++; $display("FAIL cont_ptr: got own%0d,own%0d want own3,own1", log_own[base+4], log_own[base+5]); end
    endtask

    task automatic test_round_robin();
        int base;
        int a [N];
        settle();
        base = tx_n;
        for (int i = 0; i < N; i++) a[i] = ack_cnt[i];
        for (int r = 0; r < 3; r++) for (int i = 0; i < N; i++) push(i, 8'(16*i + r), 1'b1);
        wait_tx(base + 12, 1000, "rr_wait");
        wait_idle(100, "rr_idle");
        for (int k = 0; k < 12; k++) begin
            n_cmp++; if (log_own[base+k] != k % 4 || log_byte[base+k] !== 8'(16*(k%4) + k/4)) begin
                n_fail++; $display("FAIL rr_%0d: got own%0d/%h want own%0d/%h", k, log_own[base+k], log_byte[base+k], k % 4, 8'(16*(k%4) + k/4)); end
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (ack_cnt[i] - a[i] != 3) begin n_fail++; $display("FAIL rr_acks%0d: got %0d want 3", i, ack_cnt[i] - a[i]); end
        end
    endtask

    task automatic test_runaway();
        int base, a1;
        settle();
        base = tx_n; a1 = ack_cnt[1];
        for (int k = 0; k < 66; k++) push(1, 8'(k), 1'b0);
        push(3, 8'h33, 1'b1);
        wait_tx(base + 65, 3000, "run_wait");
        n_cmp++; if (log_own[base+63] != 1 || log_byte[base+63] !== 8'h3F) begin
            n_fail++; $display("FAIL run_b63: got own%0d/%h want own1/3f", log_own[base+63], log_byte[base+63]); end
        n_cmp++; if (log_own[base+64] != 3 || log_byte[base+64] !== 8'h33) begin
            n_fail++; $display("FAIL run_next: got own%0d/%h want own3/33", log_own[base+64], log_byte[base+64]); end
        n_cmp++; if (ack_cnt[1] - a1 != 64) begin n_fail++; $display("FAIL run_acks: got %0d want 64", ack_cnt[1] - a1); end
    endtask

    task automatic test_stall();
        int base, a2, c, k;
        settle();
        base = tx_n; a2 = ack_cnt[2];
        push(2, 8'hB0, 1'b0);
        wait_tx(base + 1, 100, "stall_wait");
        c = 0;
        while (u_busy && c < 100) begin @(posedge clk); #1; c++; end
        // This sample follows the edge where the arbiter entered HOLD.
        k = 0;
        while (bus.grant !== 4'b0000 && k < 3000) begin @(posedge clk); #1; k++; end
        n_cmp++; if (k != 1023) begin n_fail++; $display("FAIL stall_timeout: got %0d cycles want 1023", k); end
        repeat (50) @(posedge clk);
        #1;
        n_cmp++; if (tx_n - base != 1) begin n_fail++; $display("FAIL stall_strobes: got %0d want 1", tx_n - base); end
        n_cmp++; if (ack_cnt[2] - a2 != 1) begin n_fail++; $display("FAIL stall_acks: got %0d want 1", ack_cnt[2] - a2); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stall_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        int base, viol, c;
        settle();
        base = tx_n;
        push(2, 8'h60, 1'b1);
        push(2, 8'h61, 1'b0); push(2, 8'h62, 1'b0); push(2, 8'h63, 1'b1);
        wait_tx(base + 3, 300, "rmid_wait");
        repeat (5) @(posedge clk);
        #1;
        apply_reset();
        n_cmp++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL rmid_grant: got %b want 0000", bus.grant); end
        n_cmp++; if (bus.uart_transmit !== 1'b0) begin n_fail++; $display("FAIL rmid_tx: got %b want 0", bus.uart_transmit); end
        n_cmp++; if (bus.uart_tx_byte !== 8'h00) begin n_fail++; $display("FAIL rmid_byte: got %h want 00", bus.uart_tx_byte); end
        push(1, 8'h71, 1'b1); push(3, 8'h73, 1'b1);
        viol = 0; c = 0;
        while (u_busy && c < 100) begin
            @(posedge clk); #1; c++;
            if (u_busy && (bus.grant !== 4'b0000 || bus.uart_transmit !== 1'b0)) viol++;
        end
        n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL rmid_quiet: got %0d early grants want 0", viol); end
        n_cmp++; if (bus.grant !== 4'b0010) begin n_fail++; $display("FAIL rmid_regrant: got %b want 0010", bus.grant); end
        wait_tx(base + 5, 300, "rmid_wait2");
        n_cmp++; if (log_own[base+3] != 1 || log_byte[base+3] !== 8'h71 || log_own[base+4] != 3 || log_byte[base+4] !== 8'h73) begin
            n_fail++; $display("FAIL rmid_order: got own%0d/%h,own%0d/%h want own1/71,own3/73",
                               log_own[base+3], log_byte[base+3], log_own[base+4], log_byte[base+4]); end
    endtask

    task automatic test_invariants();
        n_cmp++; if (inv_err != 0) begin n_fail++; $display("FAIL invariants: got %0d violations want 0", inv_err); end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            head[i] = 0; tail[i] = 0; ack_cnt[i] = 0;
            for (int j = 0; j < 256; j++) mem[i][j] = 9'h000;
        end
        bus.req = '0;
        bus.req_byte = '0;
        bus.req_last = '0;
        bus.uart_is_transmitting = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_round_robin();
        test_runaway();
        test_stall();
        test_reset_mid();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart transmitter (8-bit byte, transmit strobe, is_transmitting busy flag) between N_REQ message sources, such as print_str-style string printers and debug dumpers.
- Arbitration is per message: the winner keeps the uart until it sends a byte flagged last, so messages never interleave on the serial line.
- Priority is round-robin, with watchdogs so that a stalled or runaway requester cannot lock the uart.
- The block sits between the message generators and the single uart instance at the top of the Uart subsystem.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- MAX_MSG_LEN, 64: maximum bytes per grant; the grant is force-released after this many bytes.
- HOLD_TIMEOUT, 1023: clk cycles the granted requester may leave req low mid-message before the grant is revoked.
- GAP_CYCLES, 0: idle clk cycles inserted after each released message before the next arbitration.

Ports:
- clk, in, 1: master clock.
- rst, in, 1: synchronous, active-high reset.
- req, in, N_REQ: per-requester "byte available"; level, held until ack.
- req_byte, in, 8*N_REQ: byte for requester i in bits [8i+7:8i]; valid while req[i]=1.
- req_last, in, N_REQ: the current byte of requester i ends its message.
- req_ack, out, N_REQ: one-cycle pulse; the byte of requester i has been taken.
- grant, out, N_REQ: one-hot owner of the uart; all zero when idle.
- uart_transmit, out, 1: one-cycle strobe to the uart.
- uart_tx_byte, out, 8: byte to the uart; registered and held until the next strobe.
- uart_is_transmitting, in, 1: uart busy flag.
- busy, out, 1: high whenever state is not IDLE.

Behaviour:

Reset (rst=1 at a clk edge):
- Outputs: grant=0, req_ack=0, uart_transmit=0, uart_tx_byte=0x00, busy=0.
- Internal: state=IDLE, pointer=0, byte count=0.
- Reset mid-message aborts immediately. The uart finishes its current frame on its own; the arbiter returns to IDLE and ignores uart_is_transmitting until it is low (state WAIT_DONE is not re-entered after reset).

States: IDLE, SEND, WAIT_START, WAIT_DONE, HOLD, GAP.

IDLE:
- Enabled when uart_is_transmitting=0.
- If any req is high, the winner is the first set index scanning pointer, pointer+1, ... modulo N_REQ.
- The next cycle sets grant to the winner (one-hot), clears the byte count and enters SEND.
- Arbitration is 1 cycle: grant is visible the cycle after req is seen.

SEND (one cycle):
- Sets uart_transmit=1 and req_ack[winner]=1.
- Loads uart_tx_byte with the winner's byte and latches req_last into last_q.
- Increments the byte count, then enters WAIT_START.
- From req high in SEND to the uart_transmit strobe is 1 cycle.

WAIT_START:
- Waits for uart_is_transmitting=1, then enters WAIT_DONE.
- If it has not risen within 4 cycles, the byte is treated as sent and the block enters WAIT_DONE (tolerates a fast or absent busy flag).

WAIT_DONE:
- Waits for uart_is_transmitting=0 (falling edge seen as a level).
- If last_q=1 or byte count=MAX_MSG_LEN, the grant is released: the block enters GAP, or IDLE when GAP_CYCLES=0.
- Otherwise, if req[winner]=1 it enters SEND; if not, it enters HOLD.

HOLD:
- grant stays asserted.
- req[winner]=1 enters SEND.
- After HOLD_TIMEOUT cycles the grant is released as above.

Release:
- Clears grant and sets pointer = winner+1 modulo N_REQ.
- GAP counts down GAP_CYCLES, then enters IDLE.

Simultaneous events and other rules:
- req from non-granted requesters is ignored until release; they never receive req_ack.
- Simultaneous requests are resolved only by the pointer; there are no fixed priorities.
- A request that drops before its grant is simply not served.
- req_last on a byte equal to MAX_MSG_LEN: a single release happens (no double pointer advance).
- A requester may assert req the same cycle as its own release; it is eligible again but has lowest priority after the others.
- uart_transmit is never asserted while uart_is_transmitting=1.
- At most one req_ack bit is high per cycle.

Widths:
- Byte count is clog2(MAX_MSG_LEN+1) bits and saturates.
- HOLD/GAP counter is clog2(max(HOLD_TIMEOUT, GAP_CYCLES)+1) bits.

Test Plan:
1. Single requester: req0 with bytes "OK\n" (last on 0x0A) and a uart model busy 20 cycles per byte → three uart_transmit strobes with bytes 0x4F, 0x4B, 0x0A; three req_ack[0] pulses; grant=0001 throughout, then 0000; busy falls after the last byte.
2. Contention: req0 and req2 assert on the same cycle, 2-byte messages each, pointer=0 → req0's full message on the line, then req2's, no interleaving; pointer ends at 3.
3. Round-robin fairness: all 4 requesters continuously request 1-byte messages → grant order 0,1,2,3,0,1,... and each req_ack appears once per 4 messages.
4. Runaway: req1 never sets req_last, MAX_MSG_LEN=64 → exactly 64 acks, forced release, then pending req3 is granted.
5. Stall: req2 drops after byte 1 of a 3-byte message and stays low, HOLD_TIMEOUT=1023 → grant revoked exactly 1023 cycles after entering HOLD; no further strobes for req2.
6. Reset mid-message: rst=1 in WAIT_DONE during byte 2 → the next cycle has grant=0, uart_transmit=0, uart_tx_byte=0x00; after rst drops, no strobe until uart_is_transmitting is low; a new req then gets grant with pointer=0.
